// File: rtl/bcd_time_counter.sv
// bcd_time_counter
//   Time-of-day counter for the six-digit seven-segment display path.
//   Holds seconds/minutes/hours as binary fields, advances one second per
//   clock_en pulse, and applies single-digit up/down edits selected by a
//   one-hot digit bus. All outputs are registered BCD conversions of the
//   fields' next state, so a tick or edit sampled at edge N is visible
//   right after edge N.
//
//   Optional feature macro: TWELVE_HOUR_EN (12-hour mode with live pm flag).
//
// Ports
//   clk        system clock
//   rst_n      synchronous active-low reset, loads INIT_* time
//   clock_en   one-cycle tick, one second
//   digit[5:0] one-hot edit select: [5] sec0 [4] sec1 [3] min0 [2] min1
//              [1] hrs0 [0] hrs1
//   up, down   one-cycle edit pulses
//   sec0..hrs1 BCD digits (units/tens)
//   pm         PM flag (constant 0 in 24-hour build)
//   day_wrap   one-cycle pulse on rollover to midnight
module bcd_time_counter #(
  parameter int unsigned INIT_HRS = 0,
  parameter int unsigned INIT_MIN = 0,
  parameter int unsigned INIT_SEC = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clock_en,
  input  logic [5:0] digit,
  input  logic       up,
  input  logic       down,
  output logic [3:0] sec0,
  output logic [3:0] sec1,
  output logic [3:0] min0,
  output logic [3:0] min1,
  output logic [3:0] hrs0,
  output logic [3:0] hrs1,
  output logic       pm,
  output logic       day_wrap
);

  // Adds or subtracts d modulo m; v < m and d < m assumed (sum fits 7 bits).
  function automatic logic [6:0] step_mod(input logic [6:0] v,
                                          input logic [6:0] d,
                                          input logic [6:0] m,
                                          input logic       inc);
    logic [6:0] t;
    if (inc) t = v + d;
    else     t = v + m - d;
    if (t >= m) t = t - m;
    return t;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

`ifdef TWELVE_HOUR_EN
  localparam logic [6:0] HRS_MOD      = 7'd12;
  localparam logic [4:0] INIT_HRS_F   = 5'(INIT_HRS % 12);
  localparam logic       INIT_PM      = (INIT_HRS >= 12);
  localparam logic [6:0] INIT_HRS_DSP = (INIT_HRS % 12 == 0) ? 7'd12 : 7'(INIT_HRS % 12);
`else
  localparam logic [6:0] HRS_MOD      = 7'd24;
  localparam logic [4:0] INIT_HRS_F   = 5'(INIT_HRS);
  localparam logic [6:0] INIT_HRS_DSP = 7'(INIT_HRS);
`endif
  localparam logic [4:0] HRS_LAST   = 5'(HRS_MOD - 7'd1);
  localparam logic [5:0] INIT_MIN_F = 6'(INIT_MIN);
  localparam logic [5:0] INIT_SEC_F = 6'(INIT_SEC);

  logic [5:0] sec_q, sec_d;
  logic [5:0] min_q, min_d;
  logic [4:0] hrs_q, hrs_d;
  logic       wrap_d;
  logic [6:0] hrs_dsp_d;
  logic       onehot;
  logic       edit_ok;
`ifdef TWELVE_HOUR_EN
  logic       pm_q, pm_d;
`endif

  assign onehot  = (digit != '0) && ((digit & (digit - 6'd1)) == '0);
  assign edit_ok = onehot && (up ^ down);

  // Edits win over a coincident tick; edits never carry between fields.
  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hrs_d  = hrs_q;
    wrap_d = 1'b0;
`ifdef TWELVE_HOUR_EN
    pm_d   = pm_q;
`endif
    if (edit_ok) begin
      if (digit[5] || digit[4])
        sec_d = 6'(step_mod({1'b0, sec_q}, digit[5] ? 7'd1 : 7'd10, 7'd60, up));
      if (digit[3] || digit[2])
        min_d = 6'(step_mod({1'b0, min_q}, digit[3] ? 7'd1 : 7'd10, 7'd60, up));
      if (digit[1] || digit[0])
        hrs_d = 5'(step_mod({2'b0, hrs_q}, digit[1] ? 7'd1 : 7'd10, HRS_MOD, up));
    end else if (clock_en) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d = '0;
          if (hrs_q == HRS_LAST) begin
            hrs_d = '0;
`ifdef TWELVE_HOUR_EN
            pm_d   = ~pm_q;
            wrap_d = pm_q;
`else
            wrap_d = 1'b1;
`endif
          end else begin
            hrs_d = hrs_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  always_comb begin
    hrs_dsp_d = {2'b0, hrs_d};
`ifdef TWELVE_HOUR_EN
    if (hrs_d == '0) hrs_dsp_d = 7'd12;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec_q        <= INIT_SEC_F;
      min_q        <= INIT_MIN_F;
      hrs_q        <= INIT_HRS_F;
      day_wrap     <= 1'b0;
      {sec1, sec0} <= to_bcd({1'b0, INIT_SEC_F});
      {min1, min0} <= to_bcd({1'b0, INIT_MIN_F});
      {hrs1, hrs0} <= to_bcd(INIT_HRS_DSP);
`ifdef TWELVE_HOUR_EN
      pm_q         <= INIT_PM;
`endif
    end else begin
      sec_q        <= sec_d;
      min_q        <= min_d;
      hrs_q        <= hrs_d;
      day_wrap     <= wrap_d;
      {sec1, sec0} <= to_bcd({1'b0, sec_d});
      {min1, min0} <= to_bcd({1'b0, min_d});
      {hrs1, hrs0} <= to_bcd(hrs_dsp_d);
`ifdef TWELVE_HOUR_EN
      pm_q         <= pm_d;
`endif
    end
  end

`ifdef TWELVE_HOUR_EN
  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Testbench for bcd_time_counter (24-hour build). Expected displays come
// from a bench-side time model, pushed to a scoreboard queue as stimulus is
// driven; observed displays are queued after each edge and each test task
// drains both queues with its own comparisons.
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clock_en = 1'b0;
  logic [5:0] digit = '0;
  logic       up = 1'b0;
  logic       down = 1'b0;
  logic [3:0] sec0, sec1, min0, min1, hrs0, hrs1;
  logic       pm, day_wrap;
  logic [3:0] i_sec0, i_sec1, i_min0, i_min1, i_hrs0, i_hrs1;
  logic       i_pm, i_day_wrap;

  always #5 clk = ~clk;

  bcd_time_counter dut (
    .clk(clk), .rst_n(rst_n), .clock_en(clock_en), .digit(digit),
    .up(up), .down(down),
    .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1),
    .hrs0(hrs0), .hrs1(hrs1), .pm(pm), .day_wrap(day_wrap)
  );

  bcd_time_counter #(.INIT_HRS(13), .INIT_MIN(45), .INIT_SEC(30)) dut_init (
    .clk(clk), .rst_n(rst_n), .clock_en(clock_en), .digit(digit),
    .up(up), .down(down),
    .sec0(i_sec0), .sec1(i_sec1), .min0(i_min0), .min1(i_min1),
    .hrs0(i_hrs0), .hrs1(i_hrs1), .pm(i_pm), .day_wrap(i_day_wrap)
  );

  // {hrs1,hrs0,min1,min0,sec1,sec0,pm,day_wrap}
  logic [25:0] sb[$];
  logic [25:0] got_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int mh = 0, mm = 0, ms = 0;

  function automatic logic [25:0] pack_exp(input int h, input int m, input int s,
                                            input logic w);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
            4'(s / 10), 4'(s % 10), 1'b0, w};
  endfunction

  // Drive one cycle, update the model, queue expected and observed values.
  task automatic apply(input logic t, input logic [5:0] dg, input logic u,
                       input logic dn, input logic r);
    logic w;
    int total;
    w = 1'b0;
    clock_en = t; digit = dg; up = u; down = dn; rst_n = r;
    if (!r) begin
      mh = 0; mm = 0; ms = 0;
    end else if ($countones(dg) == 1 && u != dn) begin
      case (dg)
        6'b100000: ms = (ms + (u ? 1  : 59)) % 60;
        6'b010000: ms = (ms + (u ? 10 : 50)) % 60;
        6'b001000: mm = (mm + (u ? 1  : 59)) % 60;
        6'b000100: mm = (mm + (u ? 10 : 50)) % 60;
        6'b000010: mh = (mh + (u ? 1  : 23)) % 24;
        default:   mh = (mh + (u ? 10 : 14)) % 24;
      endcase
    end else if (t) begin
      total = mh * 3600 + mm * 60 + ms + 1;
      if (total == 86400) begin
        total = 0;
        w = 1'b1;
      end
      mh = total / 3600; mm = (total / 60) % 60; ms = total % 60;
    end
    sb.push_back(pack_exp(mh, mm, ms, w));
    @(posedge clk);
    #1;
    got_q.push_back({hrs1, hrs0, min1, min0, sec1, sec0, pm, day_wrap});
    clock_en = 1'b0; digit = '0; up = 1'b0; down = 1'b0; rst_n = 1'b1;
  endtask

  // Reach a target time from reset using tens/units edits; entries discarded.
  task automatic set_time(input int h, input int m, input int s);
    apply(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < h / 10; i++) apply(1'b0, 6'b000001, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < h % 10; i++) apply(1'b0, 6'b000010, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < m / 10; i++) apply(1'b0, 6'b000100, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < m % 10; i++) apply(1'b0, 6'b001000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < s / 10; i++) apply(1'b0, 6'b010000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < s % 10; i++) apply(1'b0, 6'b100000, 1'b1, 1'b0, 1'b1);
    sb.delete();
    got_q.delete();
  endtask

  task automatic test_reset;
    logic [25:0] e, g;
    apply(1'b0, '0, 1'b0, 1'b0, 1'b0);
    apply(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_chk++;
    if ({i_hrs1, i_hrs0, i_min1, i_min0, i_sec1, i_sec0, i_pm, i_day_wrap}
        !== pack_exp(13, 45, 30, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_init: got %h expected %h",
               {i_hrs1, i_hrs0, i_min1, i_min0, i_sec1, i_sec0, i_pm, i_day_wrap},
               pack_exp(13, 45, 30, 1'b0));
    end
    apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); g = got_q.pop_front(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL reset[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_rollover;
    logic [25:0] e, g;
    set_time(23, 59, 58);
    apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, '0, 1'b0, 1'b0, 1'b1);
    apply(1'b1, '0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); g = got_q.pop_front(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL rollover[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_edit_wrap;
    logic [25:0] e, g;
    set_time(0, 0, 0);
    apply(1'b0, 6'b000010, 1'b0, 1'b1, 1'b1);
    apply(1'b0, 6'b001000, 1'b0, 1'b1, 1'b1);
    apply(1'b0, 6'b000100, 1'b1, 1'b0, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); g = got_q.pop_front(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL edit_wrap_a[%0d]: got %h expected %h", i, g, e);
      end
    end
    set_time(15, 0, 0);
    apply(1'b0, 6'b000001, 1'b1, 1'b0, 1'b1);
    apply(1'b0, 6'b000001, 1'b0, 1'b1, 1'b1);
    set_time(12, 34, 55);
    apply(1'b0, 6'b010000, 1'b1, 1'b0, 1'b1);
    set_time(0, 0, 3);
    apply(1'b0, 6'b010000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); g = got_q.pop_front(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL edit_wrap_b[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_conflicts;
    logic [25:0] e, g;
    set_time(10, 20, 30);
    apply(1'b0, 6'b100000, 1'b1, 1'b1, 1'b1);
    apply(1'b0, 6'b000011, 1'b1, 1'b0, 1'b1);
    apply(1'b0, 6'b000000, 1'b1, 1'b0, 1'b1);
    apply(1'b1, 6'b110000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); g = got_q.pop_front(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL conflict_a[%0d]: got %h expected %h", i, g, e);
      end
    end
    set_time(0, 0, 8);
    apply(1'b1, 6'b100000, 1'b1, 1'b0, 1'b1);
    set_time(23, 59, 59);
    apply(1'b1, 6'b001000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); g = got_q.pop_front(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL conflict_b[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [25:0] e, g;
    set_time(9, 59, 57);
    for (int i = 0; i < 6; i++) apply(1'b1, '0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 6'b001000, 1'b1, 1'b0, 1'b1);
    apply(1'b1, '0, 1'b0, 1'b0, 1'b1);
    apply(1'b0, 6'b000010, 1'b0, 1'b1, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); g = got_q.pop_front(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL back_to_back[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [25:0] e, g;
    set_time(10, 20, 30);
    apply(1'b1, 6'b100000, 1'b1, 1'b0, 1'b0);
    apply(1'b1, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); g = got_q.pop_front(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL reset_mid[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  task automatic test_random;
    logic [25:0] e, g;
    logic [5:0]  dg;
    set_time(23, 58, 50);
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       dg = 6'b000001 << $urandom_range(0, 5);
        1:       dg = 6'($urandom);
        default: dg = '0;
      endcase
      apply(($urandom_range(0, 3) != 0), dg, 1'($urandom), 1'($urandom),
            ($urandom_range(0, 99) != 0));
    end
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front(); g = got_q.pop_front(); n_chk++;
      if (g !== e) begin
        n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, g, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_edit_wrap();
    test_conflicts();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_time_counter.md
# bcd_time_counter

Time-of-day counter feeding the six-digit seven-segment display path. Keeps hours, minutes and seconds as six BCD digits and advances one second per `clock_en` pulse. Applies single-digit edits from debounced, one-cycle `up`/`down` pulses to the digit chosen by the one-hot `digit` select. Its BCD outputs drive the per-digit `dec7` decoders and the display multiplexer.

## Interface
- `INIT_HRS`, default 0: reset hour, 0..23.
- `INIT_MIN`, default 0: reset minute, 0..59.
- `INIT_SEC`, default 0: reset second, 0..59.
- `clk` input 1: single clock, 6 MHz system clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `clock_en` input 1: one-cycle tick, one per second.
- `digit` input 6: one-hot edit select.
  - `[5]` selects sec0, `[4]` sec1, `[3]` min0, `[2]` min1, `[1]` hrs0, `[0]` hrs1.
- `up` input 1: one-cycle increment pulse.
- `down` input 1: one-cycle decrement pulse.
- `sec0`, `sec1`, `min0`, `min1`, `hrs0`, `hrs1` output 4 each: BCD digits (units, tens).
- `pm` output 1: PM flag. Constant 0 unless `TWELVE_HOUR_EN` is defined.
- `day_wrap` output 1: one-cycle pulse on rollover to midnight.

## Operation
- State is three binary fields: seconds 0..59, minutes 0..59, hours 0..23.
  - With `TWELVE_HOUR_EN`, hours is 0..11 plus the `pm` bit.
- BCD outputs are registered conversions of the fields. Tens digit = value/10, units = value%10. Unused BCD codes never appear.
- Reset (`rst_n`=0 at a clock edge):
  - Fields load `INIT_*`.
  - `day_wrap`=0.
  - Outputs show the init time on the edge after reset.
- Tick (`clock_en`=1, no edit this cycle):
  - sec+1.
  - At 59: sec=0, min+1.
  - At min 59: min=0, hrs+1.
  - At hrs 23: hrs=0 and `day_wrap` pulses.
- Edit: valid only when `digit` is exactly one-hot and exactly one of `up`/`down` is high. Each edit changes only its own field; there is no carry between fields.
  - sec0 ±1 and sec1 ±10 are applied modulo 60. Examples: 55+10→05, 03−10→53.
  - min0 ±1 and min1 ±10 are applied modulo 60.
  - hrs0 ±1 and hrs1 ±10 are applied modulo 24. Examples: 15+10→01, 00−1→23.
- `up` and `down` high together: both ignored.
- Non-one-hot `digit` (zero or multiple bits): edit ignored.
- Edit and `clock_en` in the same cycle: the edit is applied and that tick is discarded. This rule is fixed; the bench checks it.
- Edits never assert `day_wrap`.

## Timing
- All outputs are registered.
- Tick or edit sampled at edge N → new digits visible after edge N.
- `day_wrap` is high for exactly the one cycle after the rolling edge.
- Latency is 1 cycle and there is no internal pipeline. Back-to-back pulses on consecutive cycles are each applied.
- Reset during any activity wins. That cycle's tick and edit are discarded.
- `clock_en` held high continuously advances one second per clock. This is the speed-up test mode.

## Configuration
- `TWELVE_HOUR_EN` defined: 12-hour mode.
  - Hours field 0..11, displayed 12 when 0 (so `hrs1`/`hrs0` read 1,2). `pm` is live.
  - Tick 11:59:59 → 12:00:00 toggles `pm`.
  - `day_wrap` pulses only when `pm` goes 1→0.
  - Hour edits: hrs0 ±1 and hrs1 ±10 modulo 12; `pm` unchanged.
  - Reset: hours = `INIT_HRS`%12, `pm` = (`INIT_HRS`≥12).
- `TWELVE_HOUR_EN` not defined:
  - 24-hour behaviour as above.
  - `pm` tied 0.

## Test plan
- Reset check: `INIT_*`=0, hold `rst_n`=0 two cycles, release → all digits 0, `day_wrap`=0. With `INIT_HRS`=13, `INIT_MIN`=45, `INIT_SEC`=30 → digits read 13:45:30.
- Rollover: preset 23:59:58, two `clock_en` pulses → 23:59:59, then 00:00:00 with `day_wrap` high exactly one cycle.
- Edit wrap, 24-hour mode:
  - `digit`=000010, `down` at 00:00:00 → 23:00:00.
  - `digit`=000001, `up` from 15:00:00 → 01:00:00.
  - `digit`=010000, `up` at 12:34:55 → 12:34:05 with minutes unchanged.
- Conflicts:
  - `up` and `down` together → no change.
  - `digit`=000011 with `up` → no change.
  - `up` on `digit`=100000 together with `clock_en` at 00:00:08 → 00:00:09, not 00:00:10.
- Reset mid-operation: assert `rst_n`=0 in the same cycle as `clock_en` and `up` → next output is the init time.
- `TWELVE_HOUR_EN` build:
  - Reset with `INIT_HRS`=0 → 12:00:00, `pm`=0.
  - 11:59:59 `pm`=0 + tick → 12:00:00 `pm`=1, `day_wrap`=0.
  - 11:59:59 `pm`=1 + tick → 12:00:00 `pm`=0, `day_wrap` pulse.
